// File: rtl/instruction_fetch_memory.sv
// Byte-wide instruction memory for the fetch stage: loaded during BOOT, then serves
// registered one-cycle fetches with stall/flush, fault flags and a saturating fetch counter.
module instruction_fetch_memory #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [31:0]           loadData,
  input  logic                  loadDone,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] instructionAddress,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  instrValid,
  output logic                  misaligned,
  output logic                  outOfRange,
  output logic                  ready,
  output logic [CNT_WIDTH-1:0]  fetchCount
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

  typedef enum logic {BOOT, RUN} state_e;

  state_e               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 mis_q, mis_d;
  logic                 oor_q, oor_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [7:0]       mem [DEPTH_BYTES];
  logic             wr_en;
  logic [IDX_W-1:0] wr_base;
  logic [IDX_W-1:0] rd_base;
  logic [31:0]      rd_word;
  logic             unused_load_hi;

  // Upper load-address bits are dropped so loads wrap modulo the depth.
  assign unused_load_hi = ^loadAddr[ADDR_WIDTH-1:IDX_W];

  always_comb begin
    wr_en   = (state_q == BOOT) && loadEn && !rst;
    wr_base = loadAddr[IDX_W-1:0] & ~IDX_W'(3);
    rd_base = instructionAddress[IDX_W-1:0];
    if (BIG_ENDIAN) begin
      rd_word = {mem[rd_base], mem[rd_base + IDX_W'(1)],
                 mem[rd_base + IDX_W'(2)], mem[rd_base + IDX_W'(3)]};
    end else begin
      rd_word = {mem[rd_base + IDX_W'(3)], mem[rd_base + IDX_W'(2)],
                 mem[rd_base + IDX_W'(1)], mem[rd_base]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (BIG_ENDIAN) mem[wr_base + IDX_W'(k)] <= loadData[8*(3-k) +: 8];
        else            mem[wr_base + IDX_W'(k)] <= loadData[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    oor_d   = oor_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        if (loadDone) state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          instr_d = '0;
          valid_d = 1'b0;
          mis_d   = 1'b0;
          oor_d   = 1'b0;
        end else if (!stall) begin
          if (fetchReq) begin
            mis_d   = instructionAddress[1:0] != 2'b00;
            oor_d   = instructionAddress > LAST_WORD;
            valid_d = 1'b1;
            if (mis_d || oor_d) begin
              instr_d = '0;
            end else begin
              instr_d = rd_word;
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
          end else begin
            instr_d = '0;
            valid_d = 1'b0;
            mis_d   = 1'b0;
            oor_d   = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instruction = instr_q;
  assign instrValid  = valid_q;
  assign misaligned  = mis_q;
  assign outOfRange  = oor_q;
  assign ready       = (state_q == RUN);
  assign fetchCount  = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Scoreboard bench: stimulus queues expected outputs stamped with the cycle they are due;
// a negedge monitor pops and compares them against two differently-parameterised instances.
module tb_instruction_fetch_memory;

  typedef struct {
    int unsigned due;
    logic [31:0] instr;
    logic        v, mis, oor, rdy;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults (4 KiB, big-endian, 16-bit counter)
  logic        a_rst, a_le, a_ld, a_fr, a_st, a_fl;
  logic [31:0] a_laddr, a_ldata, a_addr;
  logic [31:0] a_instr;
  logic        a_v, a_mis, a_oor, a_rdy;
  logic [15:0] a_cnt;

  instruction_fetch_memory dut_a (
    .clk(clk), .rst(a_rst), .loadEn(a_le), .loadAddr(a_laddr), .loadData(a_ldata),
    .loadDone(a_ld), .fetchReq(a_fr), .instructionAddress(a_addr), .stall(a_st),
    .flush(a_fl), .instruction(a_instr), .instrValid(a_v), .misaligned(a_mis),
    .outOfRange(a_oor), .ready(a_rdy), .fetchCount(a_cnt)
  );

  // Instance B: 64 bytes, little-endian, 2-bit counter
  logic        b_rst, b_le, b_ld, b_fr, b_st, b_fl;
  logic [31:0] b_laddr, b_ldata, b_addr;
  logic [31:0] b_instr;
  logic        b_v, b_mis, b_oor, b_rdy;
  logic [1:0]  b_cnt;

  instruction_fetch_memory #(.DEPTH_BYTES(64), .ADDR_WIDTH(32), .BIG_ENDIAN(1'b0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(b_rst), .loadEn(b_le), .loadAddr(b_laddr), .loadData(b_ldata),
    .loadDone(b_ld), .fetchReq(b_fr), .instructionAddress(b_addr), .stall(b_st),
    .flush(b_fl), .instruction(b_instr), .instrValid(b_v), .misaligned(b_mis),
    .outOfRange(b_oor), .ready(b_rdy), .fetchCount(b_cnt)
  );

  task automatic compare(input string name, input exp_t e, input logic [31:0] instr,
                         input logic v, mis, oor, rdy, input logic [15:0] cnt);
    checks++;
    if (instr !== e.instr || v !== e.v || mis !== e.mis || oor !== e.oor ||
        rdy !== e.rdy || cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s cyc=%0d got instr=%h v=%b mis=%b oor=%b rdy=%b cnt=%0d want instr=%h v=%b mis=%b oor=%b rdy=%b cnt=%0d",
               name, cyc, instr, v, mis, oor, rdy, cnt, e.instr, e.v, e.mis, e.oor, e.rdy, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    while (q_a.size() > 0 && q_a[0].due == cyc) begin
      exp_t e;
      e = q_a.pop_front();
      compare("dut_a", e, a_instr, a_v, a_mis, a_oor, a_rdy, a_cnt);
    end
    while (q_b.size() > 0 && q_b[0].due == cyc) begin
      exp_t e;
      e = q_b.pop_front();
      compare("dut_b", e, b_instr, b_v, b_mis, b_oor, b_rdy, {14'b0, b_cnt});
    end
  end

  task automatic set_a(input logic rs, fr, input logic [31:0] addr, input logic st, fl,
                       le, input logic [31:0] laddr, ldata, input logic ld);
    a_rst = rs; a_fr = fr; a_addr = addr; a_st = st; a_fl = fl;
    a_le = le; a_laddr = laddr; a_ldata = ldata; a_ld = ld;
  endtask

  task automatic set_b(input logic rs, fr, input logic [31:0] addr,
                       le, input logic [31:0] laddr, ldata, input logic ld);
    b_rst = rs; b_fr = fr; b_addr = addr; b_st = 1'b0; b_fl = 1'b0;
    b_le = le; b_laddr = laddr; b_ldata = ldata; b_ld = ld;
  endtask

  // Queue the outputs expected after the next edge, then advance past it.
  task automatic exp_a(input logic [31:0] instr, input logic v, mis, oor, rdy, input logic [15:0] cnt);
    q_a.push_back('{cyc + 1, instr, v, mis, oor, rdy, cnt});
    @(posedge clk); #1;
  endtask

  task automatic exp_b(input logic [31:0] instr, input logic v, mis, oor, rdy, input logic [15:0] cnt);
    q_b.push_back('{cyc + 1, instr, v, mis, oor, rdy, cnt});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset for two cycles, then a fetch attempt in BOOT
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 0);          exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 0);          exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 1, 0, 0, 0, 0, 0, 0, 0);          exp_a(32'h0, 0, 0, 0, 0, 0);

    // Loads, including the top word and a wrapped, unaligned address (4119 -> 20)
    set_a(0, 0, 0, 0, 0, 1, 8,    32'h00221821, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 0, 0, 0, 0, 1, 12,   32'h00432024, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 0, 0, 0, 0, 1, 16,   32'h0083402B, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 0, 0, 0, 0, 1, 4092, 32'hDEADBEEF, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 0, 0, 0, 0, 1, 4119, 32'hCAFEF00D, 1); exp_a(32'h0, 0, 0, 0, 1, 0);

    // Back-to-back big-endian fetches
    set_a(0, 1, 8,    0, 0, 0, 0, 0, 0); exp_a(32'h00221821, 1, 0, 0, 1, 1);
    set_a(0, 1, 12,   0, 0, 0, 0, 0, 0); exp_a(32'h00432024, 1, 0, 0, 1, 2);
    set_a(0, 1, 16,   0, 0, 0, 0, 0, 0); exp_a(32'h0083402B, 1, 0, 0, 1, 3);
    set_a(0, 1, 4092, 0, 0, 0, 0, 0, 0); exp_a(32'hDEADBEEF, 1, 0, 0, 1, 4);
    set_a(0, 1, 20,   0, 0, 0, 0, 0, 0); exp_a(32'hCAFEF00D, 1, 0, 0, 1, 5);

    // Faults leave the counter alone
    set_a(0, 1, 6,    0, 0, 0, 0, 0, 0); exp_a(32'h0, 1, 1, 0, 1, 5);
    set_a(0, 1, 4096, 0, 0, 0, 0, 0, 0); exp_a(32'h0, 1, 0, 1, 1, 5);
    set_a(0, 1, 4098, 0, 0, 0, 0, 0, 0); exp_a(32'h0, 1, 1, 1, 1, 5);
    set_a(0, 0, 0,    0, 0, 0, 0, 0, 0); exp_a(32'h0, 0, 0, 0, 1, 5);

    // Stall holds for three cycles; stall+flush clears
    set_a(0, 1, 8,  0, 0, 0, 0, 0, 0); exp_a(32'h00221821, 1, 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) begin
      set_a(0, 1, 12, 1, 0, 0, 0, 0, 0); exp_a(32'h00221821, 1, 0, 0, 1, 6);
    end
    set_a(0, 1, 12, 1, 1, 0, 0, 0, 0); exp_a(32'h0, 0, 0, 0, 1, 6);

    // Loads in RUN are ignored
    set_a(0, 0, 0, 0, 0, 1, 8, 32'hFFFFFFFF, 1); exp_a(32'h0, 0, 0, 0, 1, 6);
    set_a(0, 1, 8, 0, 0, 0, 0, 0, 0);            exp_a(32'h00221821, 1, 0, 0, 1, 7);

    // Reset mid-stream, memory retained
    set_a(0, 1, 12, 0, 0, 0, 0, 0, 0); exp_a(32'h00432024, 1, 0, 0, 1, 8);
    set_a(1, 1, 16, 0, 0, 0, 0, 0, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 1, 8,  0, 0, 0, 0, 0, 0); exp_a(32'h0, 0, 0, 0, 0, 0);
    set_a(0, 0, 0,  0, 0, 0, 0, 0, 1); exp_a(32'h0, 0, 0, 0, 1, 0);
    set_a(0, 1, 8,  0, 0, 0, 0, 0, 0); exp_a(32'h00221821, 1, 0, 0, 1, 1);
    set_a(0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Instance B: little-endian storage and counter saturation
    set_b(1, 0, 0, 0, 0, 0, 0);                 exp_b(32'h0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 1, 0, 32'h11223344, 0);      exp_b(32'h0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 1, 4, 32'hA5A5A5A5, 1);      exp_b(32'h0, 0, 0, 0, 1, 0);
    set_b(0, 1, 0,  0, 0, 0, 0); exp_b(32'h11223344, 1, 0, 0, 1, 1);
    set_b(0, 1, 4,  0, 0, 0, 0); exp_b(32'hA5A5A5A5, 1, 0, 0, 1, 2);
    set_b(0, 1, 0,  0, 0, 0, 0); exp_b(32'h11223344, 1, 0, 0, 1, 3);
    set_b(0, 1, 4,  0, 0, 0, 0); exp_b(32'hA5A5A5A5, 1, 0, 0, 1, 3);
    set_b(0, 1, 0,  0, 0, 0, 0); exp_b(32'h11223344, 1, 0, 0, 1, 3);
    set_b(0, 1, 64, 0, 0, 0, 0); exp_b(32'h0, 1, 0, 1, 1, 3);
    set_b(0, 0, 0,  0, 0, 0, 0);

    checks++;
    if (dut_b.mem[0] !== 8'h44) begin
      errors++;
      $display("FAIL le_byte0 got %h want 44", dut_b.mem[0]);
    end
    checks++;
    if (dut_b.mem[3] !== 8'h11) begin
      errors++;
      $display("FAIL le_byte3 got %h want 11", dut_b.mem[3]);
    end

    repeat (3) @(posedge clk);
    #1;
    if (q_a.size() + q_b.size() != 0) begin
      checks += q_a.size() + q_b.size();
      errors += q_a.size() + q_b.size();
      $display("FAIL scoreboard_drain got %0d pending want 0", q_a.size() + q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised, synchronous-read instruction memory for the MIPS pipeline fetch stage. Program words are written over a load port while the block is in the BOOT state. After `loadDone` the block serves fetches with a one-cycle registered latency. It supports stall, flush, alignment and range checking, and a saturating fetch counter for performance measurement.

## Interface
- `DEPTH_BYTES`, default 4096: memory size in bytes; must be a power of two and ≥ 4.
- `ADDR_WIDTH`, default 32: width of the fetch and load address ports.
- `BIG_ENDIAN`, default 1: 1 = the byte at address A is bits [31:24] of the word; 0 = the byte at A is bits [7:0].
- `CNT_WIDTH`, default 16: width of the fetch counter.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `loadEn`, in, 1: write `loadData` at `loadAddr`; honoured only in BOOT.
- `loadAddr`, in, ADDR_WIDTH: byte address of the word to load; must be word-aligned.
- `loadData`, in, 32: program word, stored per `BIG_ENDIAN`.
- `loadDone`, in, 1: ends BOOT; honoured only in BOOT.
- `fetchReq`, in, 1: request a fetch at `instructionAddress`.
- `instructionAddress`, in, ADDR_WIDTH: byte address from the PC.
- `stall`, in, 1: hold all outputs; the request in this cycle is dropped.
- `flush`, in, 1: kill the fetch output next cycle.
- `instruction`, out, 32: registered instruction word.
- `instrValid`, out, 1: `instruction` holds a valid fetch.
- `misaligned`, out, 1: registered fault flag, `instructionAddress[1:0] != 0`.
- `outOfRange`, out, 1: registered fault flag, `instructionAddress > DEPTH_BYTES-4`.
- `ready`, out, 1: block is in RUN.
- `fetchCount`, out, CNT_WIDTH: number of valid fetches; saturates at all-ones.

## Operation
- **States.** BOOT and RUN. Reset enters BOOT.
- **BOOT → RUN.** Transition when `loadDone` is 1. If `loadEn` is 1 in the same cycle, that write is also performed.
- **RUN.** Stays in RUN until `rst`. `loadEn` and `loadDone` are ignored; memory is unchanged.
- **Load writes.** Storage is byte-wide, `DEPTH_BYTES` entries.
- A load writes 4 bytes at `loadAddr & ~3`, using the index `[log2(DEPTH_BYTES)-1:0]`.
- `loadAddr[1:0]` is ignored. Addresses beyond the depth wrap modulo `DEPTH_BYTES`.
- Memory contents are not cleared by reset.
- **Fetch in BOOT.** Fetch requests are ignored; outputs stay at their reset values.
- **Fetch in RUN, priority rst > flush > stall > fetchReq.**
  - `flush`: next cycle `instrValid`=0, `instruction`=0, both fault flags 0. The request in that cycle is discarded.
  - `stall` (no flush): every output register holds; `fetchCount` holds.
  - `fetchReq`, address aligned and in range: `instruction` = the 4 bytes at A..A+3 assembled per `BIG_ENDIAN`; `instrValid`=1; fault flags 0; `fetchCount` += 1, saturating.
  - `fetchReq` with a fault: `instruction`=0 (NOP); `instrValid`=1; `misaligned` and/or `outOfRange` set as applicable, both if both apply; counter unchanged.
  - No request, no stall, no flush: `instrValid`=0, `instruction`=0, flags 0.
- **Reads of unloaded locations.** Return whatever the memory holds (X in simulation). The bench loads every address it fetches.

## Timing
- **Reset values, one cycle after `rst` is sampled high:** `instruction`=0, `instrValid`=0, `misaligned`=0, `outOfRange`=0, `ready`=0, `fetchCount`=0, state BOOT.
- **Reset mid-operation.** Any fetch in progress is abandoned; the block returns to BOOT; memory is retained.
- **Load latency.** A load at edge N is readable by a fetch requested at edge N+1 or later, in RUN.
- **`ready`.** Goes to 1 in the cycle after the edge that samples `loadDone`. A fetch is accepted from that same cycle.
- **Fetch latency.** Request sampled at edge N → outputs valid after edge N; consumed at edge N+1. One cycle, fully pipelined, one request per cycle.
- **Stall length.** Stall may be asserted for any number of cycles; outputs stay bit-identical throughout.
- **Stall and flush together.** Flush wins; outputs clear.
- **Counter.** `fetchCount` updates on the same edge as the `instruction` it counts.

## Test plan
- **Reset and BOOT.** Assert `rst` 2 cycles → all outputs 0, `ready`=0. In BOOT, `fetchReq`=1 at address 0 → `instrValid` stays 0.
- **Load and big-endian fetch.** Load 0x00221821@8, 0x00432024@12, 0x0083402B@16, then `loadDone`. Fetch 8, 12, 16 on consecutive cycles → `instruction` = 0x00221821, 0x00432024, 0x0083402B one cycle after each request; `fetchCount`=3.
- **Little-endian variant.** Run with `BIG_ENDIAN`=0: load 0x11223344@0, fetch 0 → 0x11223344. Poke the byte at address 0 via a hierarchical read → 0x44.
- **Faults.** Fetch 6 → `misaligned`=1, `instruction`=0, `instrValid`=1. Fetch `DEPTH_BYTES` → `outOfRange`=1. Fetch `DEPTH_BYTES`+2 → both flags 1. `fetchCount` unchanged in all three cases.
- **Stall and flush.**
  - Fetch 8, then `stall` for 3 cycles with the address changed to 12 → output held at 0x00221821.
  - `stall`+`flush` together → next cycle `instrValid`=0, `instruction`=0.
- **Saturation, reset mid-run, late load.**
  - With `CNT_WIDTH`=2, fetch 5 valid words → `fetchCount`=3.
  - Assert `rst` during the fetch stream → BOOT, outputs 0. Re-issue `loadDone` and fetch 8 → 0x00221821, showing memory is retained.
  - `loadEn` in RUN writing 0xFFFFFFFF@8 → fetch 8 still returns 0x00221821.
